fmesh_inject_arbiter: RTL and testbench
=======================================

FMESH_INJECT_ARBITER -- requirements
Module: fmesh_inject_arbiter

Interface
REQ-001 SHALL have parameter NR, default 4, meaning number of requesters sharing one fmesh endpoint injection port (2..16).
REQ-002 SHALL have parameter Fw, default 32, meaning flit payload width.
REQ-003 SHALL take NX, NY, NL and EAw from pronoc_pkg.
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port reset, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, NR, meaning per-requester flit valid.
REQ-007 SHALL have port req_hdr / req_tail, input, NR each, meaning head and tail flags.
REQ-008 SHALL have port req_dest, input, NR*EAw, meaning destination endpoint address; sampled on head only.
REQ-009 SHALL have port req_data, input, NR*Fw, meaning flit payload.
REQ-010 SHALL have port req_ready, output, NR, meaning flit accepted when valid&ready.
REQ-011 SHALL have ports out_valid, out_hdr, out_tail, output, 1 each, meaning registered output flit and its flags.
REQ-012 SHALL have ports out_data (Fw), out_dest (EAw) and out_src (log2(NR)), output.
REQ-013 SHALL have port out_ready, input, 1, meaning downstream accepts.
REQ-014 SHALL have port err_drop, output, 1, meaning one-cycle pulse on an invalid-destination head.
REQ-015 SHALL have port err_proto, output, 1, meaning one-cycle pulse on a head seen while locked.
REQ-016 SHALL have port drop_cnt, output, 8, meaning count of dropped packets.

Function
REQ-017 SHALL have states IDLE, LOCKED and DROP.
REQ-018 IDLE: SHALL consider only requesters with req_valid&req_hdr; non-head flits get ready=0.
REQ-019 IDLE: SHALL grant round-robin, searching from rr_ptr+1 upward with wrap.
REQ-020 SHALL define accept-space as ~out_valid | out_ready.
REQ-021 In IDLE and LOCKED, SHALL assert req_ready only for the granted/owner requester when accept-space is true.
REQ-022 On an accepted valid-destination head: SHALL load the output register next cycle (latency 1), capture out_dest and out_src, and go to LOCKED; a hdr&tail flit SHALL stay in IDLE.
REQ-023 LOCKED: SHALL serve only the owner; on accepted tail SHALL go to IDLE with rr_ptr<=owner.
REQ-024 Single-flit packet: SHALL set rr_ptr<=owner.
REQ-025 Destination validity SHALL be the fmesh address-decode valid (x<=NX-1, y<=NY-1, port<=NL+3).
REQ-026 Invalid head: SHALL assert req_ready regardless of output space, pulse err_drop and increment drop_cnt (saturating at 255).
REQ-027 After an invalid head: SHALL go to DROP (stay IDLE if tail); no output is produced.
REQ-028 DROP: SHALL sink owner flits with ready=1 until tail, then go to IDLE with rr_ptr<=owner.
REQ-029 Owner head while LOCKED: SHALL forward it as a body flit, pulse err_proto, and keep out_dest unchanged.
REQ-030 out_valid SHALL clear when out_ready and no new flit is accepted in that cycle.
REQ-031 Output SHALL hold stable while out_valid & ~out_ready.
REQ-032 Simultaneous drain and accept SHALL yield back-to-back flits with no bubble.

Reset
REQ-033 On reset low, SHALL asynchronously force: state IDLE, rr_ptr NR-1, out_valid 0, all out_* 0, err_* 0, drop_cnt 0.
REQ-034 Reset mid-packet SHALL abandon the packet; the first grant after release SHALL go to requester 0 if its head is valid.

Structure
REQ-035 The state enum SHALL be local; no new package entries are required beyond the existing pronoc_pkg constants.
REQ-036 Destination checking SHALL instantiate the existing fmesh_endp_addr_decode sub-module on the muxed head destination.

Verification
REQ-037 All 4 requesters present 1-flit heads continuously with out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out_valid from cycle 1.
REQ-038 Req 2 sends a 3-flit packet while req 0 waits -> out_src=2 for 3 flits, then req 0 granted; out_dest constant across the packet.
REQ-039 NX=NY=2 and head dest with x=3 -> err_drop pulses once, drop_cnt=1, flits sunk until tail, out_valid stays 0.
REQ-040 out_ready=0 for 5 cycles mid-packet -> output held stable, req_ready=0, no flit loss on resume.
REQ-041 reset low during flit 2 of 4 -> outputs zero immediately; after release, requester 0 head granted first.

Source files
------------

// File: rtl/pronoc_pkg.sv
// Shared fmesh NoC constants used by the injection arbiter and its address decoder.
// Endpoint address layout (LSB first): x | y | port.
// The x and y fields are one bit wider than the 2x2 mesh needs, so out-of-range
// coordinates (for example x=3) can be carried and then rejected by the decoder.
package pronoc_pkg;

    localparam int NX  = 2;
    localparam int NY  = 2;
    localparam int NL  = 1;
    localparam int Xw  = 2;
    localparam int Yw  = 2;
    localparam int Pw  = 3;
    localparam int EAw = Xw + Yw + Pw;

    // Build an endpoint address from its x, y and port fields
    function automatic logic [EAw-1:0] fmesh_addr(
        input logic [Xw-1:0] x,
        input logic [Yw-1:0] y,
        input logic [Pw-1:0] p
    );
        return {p, y, x};
    endfunction

endpackage

// File: rtl/fmesh_inject_arbiter_if.sv
// Bundle of requester-side and output-side signals of the fmesh injection arbiter.
//   master : requesters plus downstream sink (drives req_*, out_ready)
//   slave  : the arbiter (drives req_ready, out_*, err_*, drop_cnt)
interface fmesh_inject_arbiter_if #(
    parameter int NR  = 4,
    parameter int Fw  = 32,
    parameter int EAw = pronoc_pkg::EAw
);
    localparam int Sw = (NR > 1) ? $clog2(NR) : 1;

    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_hdr;
    logic [NR-1:0]     req_tail;
    logic [NR*EAw-1:0] req_dest;
    logic [NR*Fw-1:0]  req_data;
    logic [NR-1:0]     req_ready;

    logic              out_valid;
    logic              out_hdr;
    logic              out_tail;
    logic [Fw-1:0]     out_data;
    logic [EAw-1:0]    out_dest;
    logic [Sw-1:0]     out_src;
    logic              out_ready;

    logic              err_drop;
    logic              err_proto;
    logic [7:0]        drop_cnt;

    modport master (
        output req_valid, req_hdr, req_tail, req_dest, req_data, out_ready,
        input  req_ready, out_valid, out_hdr, out_tail, out_data, out_dest, out_src,
        input  err_drop, err_proto, drop_cnt
    );

    modport slave (
        input  req_valid, req_hdr, req_tail, req_dest, req_data, out_ready,
        output req_ready, out_valid, out_hdr, out_tail, out_data, out_dest, out_src,
        output err_drop, err_proto, drop_cnt
    );

endinterface

// File: rtl/fmesh_endp_addr_decode.sv
// fmesh endpoint address decoder: splits an address into x / y / port and flags
// whether it names an existing endpoint of the mesh.
//   addr  : endpoint address {port, y, x}
//   valid : x <= NX-1, y <= NY-1 and port <= NL+3
module fmesh_endp_addr_decode
    import pronoc_pkg::*;
(
    input  logic [EAw-1:0] addr,
    output logic           valid
);

    localparam logic [Xw-1:0] X_MAX = Xw'(NX - 1);
    localparam logic [Yw-1:0] Y_MAX = Yw'(NY - 1);
    localparam logic [Pw-1:0] P_MAX = Pw'(NL + 3);

    logic [Xw-1:0] x_s;
    logic [Yw-1:0] y_s;
    logic [Pw-1:0] port_s;

    assign x_s    = addr[Xw-1:0];
    assign y_s    = addr[Xw +: Yw];
    assign port_s = addr[Xw+Yw +: Pw];

    // Range check of every address field
    always_comb begin
        valid = (x_s <= X_MAX) && (y_s <= Y_MAX) && (port_s <= P_MAX);
    end

endmodule

// File: rtl/fmesh_inject_arbiter.sv
// Round-robin arbiter sharing one fmesh endpoint injection port among NR requesters.
// Packets are granted whole (head to tail); heads with an unroutable destination are
// sunk and counted instead of forwarded. The output flit is held in a single register.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : slave side of fmesh_inject_arbiter_if (requests, output flit, errors)
module fmesh_inject_arbiter
    import pronoc_pkg::*;
#(
    parameter int NR = 4,
    parameter int Fw = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    fmesh_inject_arbiter_if.slave  bus
);

    localparam int Sw = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t          state_r;
    logic [Sw-1:0]   rr_ptr_r;
    logic [Sw-1:0]   owner_r;
    logic            out_valid_r;
    logic            out_hdr_r;
    logic            out_tail_r;
    logic [Fw-1:0]   out_data_r;
    logic [EAw-1:0]  out_dest_r;
    logic [Sw-1:0]   out_src_r;
    logic            err_drop_r;
    logic            err_proto_r;
    logic [7:0]      drop_cnt_r;

    logic [NR-1:0]   head_req_s;
    logic [Sw-1:0]   grant_s;
    logic            grant_found_s;
    logic            hit_s;
    int              cand_s;
    logic [Sw-1:0]   sel_s;
    logic            sel_valid_s;
    logic            sel_hdr_s;
    logic            sel_tail_s;
    logic [Fw-1:0]   sel_data_s;
    logic [EAw-1:0]  sel_dest_s;
    logic            dest_ok_s;
    logic            space_s;
    logic [NR-1:0]   ready_s;
    logic            accept_s;

    // Round-robin search over valid heads, starting just after the last served requester
    always_comb begin
        head_req_s    = bus.req_valid & bus.req_hdr;
        grant_s       = '0;
        grant_found_s = 1'b0;
        hit_s         = 1'b0;
        cand_s        = 0;
        for (int k = 1; k <= NR; k++) begin
            cand_s        = (int'(rr_ptr_r) + k) % NR;
            hit_s         = !grant_found_s && head_req_s[cand_s];
            grant_s       = hit_s ? Sw'(cand_s) : grant_s;
            grant_found_s = grant_found_s | hit_s;
        end
    end

    // Flit mux: the grant candidate while idle, the packet owner otherwise
    always_comb begin
        sel_s       = (state_r == ST_IDLE) ? grant_s : owner_r;
        sel_valid_s = bus.req_valid[sel_s];
        sel_hdr_s   = bus.req_hdr[sel_s];
        sel_tail_s  = bus.req_tail[sel_s];
        sel_data_s  = bus.req_data[int'(sel_s) * Fw +: Fw];
        sel_dest_s  = bus.req_dest[int'(sel_s) * EAw +: EAw];
    end

    fmesh_endp_addr_decode u_addr_decode (
        .addr  (sel_dest_s),
        .valid (dest_ok_s)
    );

    // Output register can take a flit if it is empty or being drained this cycle
    assign space_s = ~out_valid_r | bus.out_ready;

    // Per-requester ready; invalid heads and dropped packets are sunk without output space
    always_comb begin
        ready_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    ready_s[grant_s] = dest_ok_s ? space_s : 1'b1;
                end else begin
                    ready_s = '0;
                end
            end
            ST_LOCKED: ready_s[owner_r] = space_s;
            ST_DROP:   ready_s[owner_r] = 1'b1;
            default:   ready_s = '0;
        endcase
        accept_s = sel_valid_s & ready_s[sel_s];
    end

    // Packet FSM, round-robin pointer, output register and error reporting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= Sw'(NR - 1);
            owner_r     <= '0;
            out_valid_r <= 1'b0;
            out_hdr_r   <= 1'b0;
            out_tail_r  <= 1'b0;
            out_data_r  <= '0;
            out_dest_r  <= '0;
            out_src_r   <= '0;
            err_drop_r  <= 1'b0;
            err_proto_r <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            err_drop_r  <= 1'b0;
            err_proto_r <= 1'b0;
            // Drained flit leaves unless a new one is loaded below in the same cycle
            if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (dest_ok_s) begin
                            out_valid_r <= 1'b1;
                            out_hdr_r   <= 1'b1;
                            out_tail_r  <= sel_tail_s;
                            out_data_r  <= sel_data_s;
                            out_dest_r  <= sel_dest_s;
                            out_src_r   <= grant_s;
                            if (sel_tail_s) begin
                                rr_ptr_r <= grant_s;
                            end else begin
                                owner_r <= grant_s;
                                state_r <= ST_LOCKED;
                            end
                        end else begin
                            err_drop_r <= 1'b1;
                            if (drop_cnt_r != 8'd255) begin
                                drop_cnt_r <= drop_cnt_r + 8'd1;
                            end
                            if (sel_tail_s) begin
                                rr_ptr_r <= grant_s;
                            end else begin
                                owner_r <= grant_s;
                                state_r <= ST_DROP;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept_s) begin
                        // A stray head inside a packet travels on as a body flit
                        out_valid_r <= 1'b1;
                        out_hdr_r   <= 1'b0;
                        out_tail_r  <= sel_tail_s;
                        out_data_r  <= sel_data_s;
                        out_src_r   <= owner_r;
                        err_proto_r <= sel_hdr_s;
                        if (sel_tail_s) begin
                            rr_ptr_r <= owner_r;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept_s && sel_tail_s) begin
                        rr_ptr_r <= owner_r;
                        state_r  <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_hdr   = out_hdr_r;
    assign bus.out_tail  = out_tail_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_dest  = out_dest_r;
    assign bus.out_src   = out_src_r;
    assign bus.err_drop  = err_drop_r;
    assign bus.err_proto = err_proto_r;
    assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_fmesh_inject_arbiter.sv
// Self-checking bench for fmesh_inject_arbiter. Requesters replay per-requester flit
// queues; a packet-level reference model predicts ready, output order and error pulses.
module tb_fmesh_inject_arbiter;
    import pronoc_pkg::*;

    localparam int NR = 4;
    localparam int Fw = 32;

    typedef struct {
        logic           hdr;
        logic           tail;
        logic [EAw-1:0] dest;
        logic [Fw-1:0]  data;
    } flit_t;

    typedef struct {
        logic           hdr;
        logic           tail;
        logic [EAw-1:0] dest;
        int             src;
        logic [Fw-1:0]  data;
    } oflit_t;

    logic clk = 1'b0;
    logic reset;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    fmesh_inject_arbiter_if #(.NR(NR), .Fw(Fw)) bus ();

    fmesh_inject_arbiter #(.NR(NR), .Fw(Fw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    flit_t  str_q [NR][$];
    bit     vld [NR];
    oflit_t out_q [$];
    int     deliv_q [$];
    int     m_owner;
    int     m_last;
    int     m_drops;
    bit     m_drop;
    logic [EAw-1:0] m_dest;
    bit     exp_err_drop;
    bit     exp_err_proto;
    int     valid_pct = 100;
    int     ready_pct = 100;

    // Hard time limit so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, want);
        end
    endtask

    function automatic bit dest_ok(input logic [EAw-1:0] d);
        int a, x, y, p;
        a = int'(d);
        x = a % (1 << Xw);
        y = (a >> Xw) % (1 << Yw);
        p = a >> (Xw + Yw);
        return (x < NX) && (y < NY) && (p <= NL + 3);
    endfunction

    function automatic logic [EAw-1:0] pick_dest(input bit bad);
        int x, y, p, w;
        x = $urandom_range(NX - 1);
        y = $urandom_range(NY - 1);
        p = $urandom_range(NL + 3);
        if (bad) begin
            w = $urandom_range(2);
            if (w == 0)      x = $urandom_range((1 << Xw) - 1, NX);
            else if (w == 1) y = $urandom_range((1 << Yw) - 1, NY);
            else             p = $urandom_range((1 << Pw) - 1, NL + 4);
        end
        return fmesh_addr(Xw'(x), Yw'(y), Pw'(p));
    endfunction

    task automatic add_pkt(input int r, input int len, input logic [EAw-1:0] dest, input bit proto);
        flit_t f;
        for (int i = 0; i < len; i++) begin
            f.hdr  = (i == 0) || (proto && i == 1);
            f.tail = (i == len - 1);
            f.dest = dest;
            f.data = $urandom();
            str_q[r].push_back(f);
        end
    endtask

    task automatic model_reset();
        out_q.delete();
        m_owner = -1;
        m_drop  = 1'b0;
        m_last  = NR - 1;
        m_drops = 0;
        exp_err_drop  = 1'b0;
        exp_err_proto = 1'b0;
        for (int r = 0; r < NR; r++) begin
            vld[r] = 1'b0;
            while (str_q[r].size() > 0 && !str_q[r][0].hdr) void'(str_q[r].pop_front());
        end
    endtask

    task automatic drive_inputs(input bit ordy);
        logic [NR-1:0]     v, h, t;
        logic [NR*EAw-1:0] d;
        logic [NR*Fw-1:0]  dt;
        v = '0; h = '0; t = '0; d = '0; dt = '0;
        for (int r = 0; r < NR; r++) begin
            if (!vld[r] && str_q[r].size() > 0 && $urandom_range(99) < valid_pct) vld[r] = 1'b1;
            if (vld[r]) begin
                v[r] = 1'b1;
                h[r] = str_q[r][0].hdr;
                t[r] = str_q[r][0].tail;
                d[r*EAw +: EAw] = str_q[r][0].dest;
                dt[r*Fw +: Fw]  = str_q[r][0].data;
            end
        end
        bus.req_valid = v;
        bus.req_hdr   = h;
        bus.req_tail  = t;
        bus.req_dest  = d;
        bus.req_data  = dt;
        bus.out_ready = ordy;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", bus.out_valid, out_q.size() > 0);
        if (out_q.size() > 0) begin
            check_eq("out_src",  bus.out_src,  out_q[0].src);
            check_eq("out_hdr",  bus.out_hdr,  out_q[0].hdr);
            check_eq("out_tail", bus.out_tail, out_q[0].tail);
            check_eq("out_dest", bus.out_dest, out_q[0].dest);
            check_eq("out_data", bus.out_data, out_q[0].data);
        end
        check_eq("err_drop",  bus.err_drop,  exp_err_drop);
        check_eq("err_proto", bus.err_proto, exp_err_proto);
        check_eq("drop_cnt",  bus.drop_cnt,  m_drops);
    endtask

    // One clock cycle: entered and left at a falling edge
    task automatic step(input bit ordy);
        logic [NR-1:0] exp_rdy;
        int     sel;
        bit     space, e_drop, e_proto;
        flit_t  f;
        oflit_t o;
        check_outputs();
        drive_inputs(ordy);
        #1;
        space   = (out_q.size() == 0) || ordy;
        exp_rdy = '0;
        sel     = -1;
        if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (sel < 0 && vld[c] && str_q[c][0].hdr) sel = c;
            end
            if (sel >= 0) exp_rdy[sel] = dest_ok(str_q[sel][0].dest) ? space : 1'b1;
        end else begin
            sel = m_owner;
            exp_rdy[sel] = m_drop ? 1'b1 : space;
        end
        check_eq("req_ready", bus.req_ready, exp_rdy);
        e_drop  = 1'b0;
        e_proto = 1'b0;
        if (ordy && out_q.size() > 0) begin
            deliv_q.push_back(out_q[0].src);
            void'(out_q.pop_front());
        end
        if (sel >= 0 && vld[sel] && exp_rdy[sel]) begin
            f = str_q[sel].pop_front();
            vld[sel] = 1'b0;
            o.src  = sel;
            o.tail = f.tail;
            o.data = f.data;
            if (m_owner < 0) begin
                if (dest_ok(f.dest)) begin
                    o.hdr = 1'b1; o.dest = f.dest;
                    out_q.push_back(o);
                    if (f.tail) m_last = sel;
                    else begin m_owner = sel; m_drop = 1'b0; m_dest = f.dest; end
                end else begin
                    e_drop = 1'b1;
                    if (m_drops < 255) m_drops++;
                    if (f.tail) m_last = sel;
                    else begin m_owner = sel; m_drop = 1'b1; end
                end
            end else begin
                if (!m_drop) begin
                    o.hdr = 1'b0; o.dest = m_dest;
                    out_q.push_back(o);
                    e_proto = f.hdr;
                end
                if (f.tail) begin m_last = m_owner; m_owner = -1; end
            end
        end
        exp_err_drop  = e_drop;
        exp_err_proto = e_proto;
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step($urandom_range(99) < ready_pct);
    endtask

    // Asynchronous reset pulse placed away from any rising edge
    task automatic apply_reset();
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_hdr",   bus.out_hdr,   1'b0);
        check_eq("rst_out_tail",  bus.out_tail,  1'b0);
        check_eq("rst_out_data",  bus.out_data,  '0);
        check_eq("rst_out_dest",  bus.out_dest,  '0);
        check_eq("rst_out_src",   bus.out_src,   '0);
        check_eq("rst_err_drop",  bus.err_drop,  1'b0);
        check_eq("rst_err_proto", bus.err_proto, 1'b0);
        check_eq("rst_drop_cnt",  bus.drop_cnt,  8'd0);
        model_reset();
        drive_inputs(1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int pending;
    int exp_037 [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int r = 0; r < NR; r++) vld[r] = 1'b0;
        model_reset();
        drive_inputs(1'b0);
        @(negedge clk);
        apply_reset();

        // Four requesters with continuous single-flit heads
        for (int r = 0; r < NR; r++) begin
            add_pkt(r, 1, pick_dest(1'b0), 1'b0);
            add_pkt(r, 1, pick_dest(1'b0), 1'b0);
        end
        deliv_q.delete();
        run_cycles(12);
        check_eq("rr_count", deliv_q.size(), 8);
        for (int i = 0; i < 5; i++) check_eq($sformatf("rr_grant%0d", i), deliv_q[i], exp_037[i]);

        // Three-flit packet from requester 2 while requester 0 waits
        deliv_q.delete();
        add_pkt(2, 3, pick_dest(1'b0), 1'b0);
        step(1'b1);
        add_pkt(0, 1, pick_dest(1'b0), 1'b0);
        run_cycles(8);
        check_eq("lock_count", deliv_q.size(), 4);
        for (int i = 0; i < 3; i++) check_eq($sformatf("lock_src%0d", i), deliv_q[i], 2);
        check_eq("lock_next", deliv_q[3], 0);

        // Head with x=3 on a 2x2 mesh is dropped with its body
        deliv_q.delete();
        add_pkt(1, 3, fmesh_addr(2'd3, 2'd0, 3'd0), 1'b0);
        run_cycles(6);
        check_eq("drop_cnt_one", bus.drop_cnt, 8'd1);
        check_eq("drop_no_out", deliv_q.size(), 0);

        // Downstream stall of five cycles in the middle of a packet
        deliv_q.delete();
        add_pkt(3, 4, pick_dest(1'b0), 1'b0);
        step(1'b1);
        step(1'b1);
        repeat (5) step(1'b0);
        repeat (6) step(1'b1);
        check_eq("stall_count", deliv_q.size(), 4);

        // Reset while flit 2 of a 4-flit packet is in flight
        add_pkt(2, 4, pick_dest(1'b0), 1'b0);
        step(1'b1);
        step(1'b1);
        add_pkt(3, 1, pick_dest(1'b0), 1'b0);
        add_pkt(0, 1, pick_dest(1'b0), 1'b0);
        apply_reset();
        deliv_q.delete();
        run_cycles(6);
        check_eq("post_rst_count", deliv_q.size(), 2);
        check_eq("post_rst_first", deliv_q[0], 0);

        // Drop counter saturation
        for (int i = 0; i < 260; i++) add_pkt(1, 1, fmesh_addr(2'd0, 2'd0, 3'd7), 1'b0);
        run_cycles(270);
        check_eq("drop_sat", bus.drop_cnt, 8'd255);

        // Randomised traffic: mixed lengths, bad destinations, stray heads, backpressure
        valid_pct = 60;
        ready_pct = 70;
        for (int i = 0; i < 2500; i++) begin
            for (int r = 0; r < NR; r++) begin
                if (str_q[r].size() < 3)
                    add_pkt(r, $urandom_range(4, 1), pick_dest($urandom_range(99) < 15),
                            $urandom_range(99) < 5);
            end
            run_cycles(1);
        end
        valid_pct = 100;
        ready_pct = 100;
        pending = 1;
        for (int i = 0; i < 400 && pending > 0; i++) begin
            step(1'b1);
            pending = out_q.size();
            for (int r = 0; r < NR; r++) pending += str_q[r].size();
        end
        check_eq("drain_left", pending, 0);
        step(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
